// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed 4-digit common-anode 7-segment driver with
//            digit blinking and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int c_REF_W = $clog2(REFRESH_DIV);
    localparam int c_BLK_W = $clog2(BLINK_DIV);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);

    logic [c_REF_W-1:0] r_ref_cnt;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic [1:0]         r_scan;
    logic               r_phase;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic [3:0] w_digit;
    logic [6:0] w_seg;
    logic [3:0] w_an_sel;
    logic [3:0] w_lz;
    logic       w_blank;

    assign w_digit  = digits[{r_scan, 2'b00} +: 4];
    assign w_an_sel = ~(4'b0001 << r_scan);

    // A digit is a leading zero only if it and every digit to its left is zero
    assign w_lz[3] = (digits[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] & (digits[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] & (digits[7:4] == 4'd0);
    assign w_lz[0] = 1'b0;

    assign w_blank = (blink_en & blink_mask[r_scan] & r_phase) |
                     (lz_blank & w_lz[r_scan]);

    always_comb begin
        w_seg = 7'b0111111;
        case (w_digit)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b0111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt   <= '0;
            r_blink_cnt <= '0;
            r_scan      <= 2'd0;
            r_phase     <= 1'b0;
            r_an        <= 4'b1111;
            r_seg       <= 7'b1111111;
        end else begin
            if (r_ref_cnt == c_REF_LAST) begin
                r_ref_cnt <= '0;
                r_scan    <= r_scan + 2'd1;
            end else begin
                r_ref_cnt <= r_ref_cnt + c_REF_W'(1);
            end

            // Blink timebase free-runs; blink_en only gates visibility
            if (r_blink_cnt == c_BLK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
            end

            if (w_blank) begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
            end else begin
                r_an  <= w_an_sel;
                r_seg <= w_seg;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
`default_nettype wire
